// File: rtl/regfile_mp_pkg.sv
// Shared defaults and constants for the multi-port register file.
// Imported by the register file top and its busy scoreboard.
package regfile_mp_pkg;
  localparam int XLEN_D = 32;
  localparam int NREG_D = 32;
  localparam int NRD_D  = 3;
  localparam int NWR_D  = 2;
  localparam int REG_X0 = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set at issue, cleared at write-back or flush.
// Bit 0 (x0) is hard-wired clear.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int NREG = NREG_D,
  parameter int NWR  = NWR_D,
  parameter int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_idx,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_idx,
  input  logic              flush,
  output logic [NREG-1:0]   busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_nxt;
  logic [NREG-1:0] wb_hit;

  always_comb begin
    wb_hit = '0;
    for (int k = 0; k < NWR; k++) begin
      if (wr_en[k]) wb_hit[wr_idx[k*AW +: AW]] = 1'b1;
    end
  end

  // Alloc beats write-back: the newly issued producer is still outstanding.
  always_comb begin
    busy_nxt = busy_q;
    for (int r = 1; r < NREG; r++) begin
      if (flush) busy_nxt[r] = 1'b0;
      else if (alloc_en && alloc_idx == AW'(r)) busy_nxt[r] = 1'b1;
      else if (wb_hit[r]) busy_nxt[r] = 1'b0;
    end
    busy_nxt[REG_X0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_nxt;
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with optional
// write-to-read bypass and a busy scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN   = XLEN_D,
  parameter int NREG   = NREG_D,
  parameter int NRD    = NRD_D,
  parameter int NWR    = NWR_D,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NWR-1:0]       wr_en_i,
  input  logic [NWR*AW-1:0]    wr_idx_i,
  input  logic [NWR*XLEN-1:0]  wr_data_i,
  input  logic [NRD*AW-1:0]    rd_idx_i,
  output logic [NRD*XLEN-1:0]  rd_data_o,
  output logic [NRD-1:0]       rd_ready_o,
  input  logic                 alloc_en_i,
  input  logic [AW-1:0]        alloc_idx_i,
  input  logic                 flush_i,
  output logic [NREG-1:0]      busy_o,
  output logic [NREG*XLEN-1:0] reg_data_o
);

  logic [XLEN-1:0] regs [NREG];

  // Ports are scanned low to high so the highest port's write lands last.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wr_en_i[k] && wr_idx_i[k*AW +: AW] != AW'(REG_X0))
          regs[wr_idx_i[k*AW +: AW]] <= wr_data_i[k*XLEN +: XLEN];
      end
    end
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .NWR  (NWR),
    .AW   (AW)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en_i),
    .wr_idx    (wr_idx_i),
    .alloc_en  (alloc_en_i),
    .alloc_idx (alloc_idx_i),
    .flush     (flush_i),
    .busy      (busy_o)
  );

  always_comb begin
    rd_data_o  = '0;
    rd_ready_o = '0;
    for (int j = 0; j < NRD; j++) begin
      rd_data_o[j*XLEN +: XLEN] = regs[rd_idx_i[j*AW +: AW]];
      rd_ready_o[j] = !busy_o[rd_idx_i[j*AW +: AW]];
      if (BYPASS != 0) begin
        for (int k = 0; k < NWR; k++) begin
          if (wr_en_i[k] &&
              wr_idx_i[k*AW +: AW] == rd_idx_i[j*AW +: AW]) begin
            rd_data_o[j*XLEN +: XLEN] = wr_data_i[k*XLEN +: XLEN];
            rd_ready_o[j] = 1'b1;
          end
        end
      end
      if (rd_idx_i[j*AW +: AW] == AW'(REG_X0)) begin
        rd_data_o[j*XLEN +: XLEN] = '0;
        rd_ready_o[j] = 1'b1;
      end
    end
  end

  always_comb begin
    reg_data_o = '0;
    for (int r = 1; r < NREG; r++)
      reg_data_o[r*XLEN +: XLEN] = regs[r];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench: directed checks on a default build plus a model-checked
// 16-register, 4-read, 3-write, no-bypass build.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  // Build A: defaults (XLEN 32, NREG 32, NRD 3, NWR 2, BYPASS 1)
  logic [1:0]    a_wr_en;
  logic [9:0]    a_wr_idx;
  logic [63:0]   a_wr_data;
  logic [14:0]   a_rd_idx;
  logic [95:0]   a_rd_data;
  logic [2:0]    a_rd_ready;
  logic          a_alloc_en;
  logic [4:0]    a_alloc_idx;
  logic          a_flush;
  logic [31:0]   a_busy;
  logic [1023:0] a_regs;

  regfile_mp u_a (
    .clk         (clk),
    .reset       (reset),
    .wr_en_i     (a_wr_en),
    .wr_idx_i    (a_wr_idx),
    .wr_data_i   (a_wr_data),
    .rd_idx_i    (a_rd_idx),
    .rd_data_o   (a_rd_data),
    .rd_ready_o  (a_rd_ready),
    .alloc_en_i  (a_alloc_en),
    .alloc_idx_i (a_alloc_idx),
    .flush_i     (a_flush),
    .busy_o      (a_busy),
    .reg_data_o  (a_regs)
  );

  // Build B: NREG 16, NRD 4, NWR 3, BYPASS 0
  logic [2:0]   b_wr_en;
  logic [11:0]  b_wr_idx;
  logic [95:0]  b_wr_data;
  logic [15:0]  b_rd_idx;
  logic [127:0] b_rd_data;
  logic [3:0]   b_rd_ready;
  logic         b_alloc_en;
  logic [3:0]   b_alloc_idx;
  logic         b_flush;
  logic [15:0]  b_busy;
  logic [511:0] b_regs;

  regfile_mp #(
    .XLEN(32), .NREG(16), .NRD(4), .NWR(3), .BYPASS(0)
  ) u_b (
    .clk         (clk),
    .reset       (reset),
    .wr_en_i     (b_wr_en),
    .wr_idx_i    (b_wr_idx),
    .wr_data_i   (b_wr_data),
    .rd_idx_i    (b_rd_idx),
    .rd_data_o   (b_rd_data),
    .rd_ready_o  (b_rd_ready),
    .alloc_en_i  (b_alloc_en),
    .alloc_idx_i (b_alloc_idx),
    .flush_i     (b_flush),
    .busy_o      (b_busy),
    .reg_data_o  (b_regs)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model of build B: architectural state as plain arrays.
  logic [31:0] m_reg [16];
  bit          m_busy [16];
  bit          chk_b = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 16; r++) begin
        m_reg[r] = '0;
        m_busy[r] = 0;
      end
    end else begin
      bit wb [16];
      for (int r = 0; r < 16; r++) wb[r] = 0;
      for (int k = 0; k < 3; k++) begin
        int ix;
        ix = int'(b_wr_idx[k*4 +: 4]);
        if (b_wr_en[k]) begin
          wb[ix] = 1;
          if (ix != 0) m_reg[ix] = b_wr_data[k*32 +: 32];
        end
      end
      for (int r = 1; r < 16; r++) begin
        if (b_flush) m_busy[r] = 0;
        else if (b_alloc_en && int'(b_alloc_idx) == r) m_busy[r] = 1;
        else if (wb[r]) m_busy[r] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_b) begin
      logic [127:0] e_data;
      logic [3:0]   e_rdy;
      logic [15:0]  e_busy;
      logic [511:0] e_regs;
      for (int j = 0; j < 4; j++) begin
        int ix;
        ix = int'(b_rd_idx[j*4 +: 4]);
        e_data[j*32 +: 32] = (ix == 0) ? 32'h0 : m_reg[ix];
        e_rdy[j] = (ix == 0) ? 1'b1 : !m_busy[ix];
      end
      for (int r = 0; r < 16; r++) begin
        e_busy[r] = m_busy[r];
        e_regs[r*32 +: 32] = (r == 0) ? 32'h0 : m_reg[r];
      end
      n_tests++;
      if (b_rd_data !== e_data || b_rd_ready !== e_rdy) begin
        n_fail++;
        $display("FAIL b_read: got %h/%b expected %h/%b",
                 b_rd_data, b_rd_ready, e_data, e_rdy);
      end
      n_tests++;
      if (b_busy !== e_busy) begin
        n_fail++;
        $display("FAIL b_busy: got %h expected %h", b_busy, e_busy);
      end
      n_tests++;
      if (b_regs !== e_regs) begin
        n_fail++;
        $display("FAIL b_regs: got %h expected %h", b_regs, e_regs);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_wr_en = '0; a_wr_idx = '0; a_wr_data = '0;
    a_rd_idx = '0; a_alloc_en = 0; a_alloc_idx = '0;
    a_flush = 0;
    b_wr_en = '0; b_wr_idx = '0; b_wr_data = '0;
    b_rd_idx = '0; b_alloc_en = 0; b_alloc_idx = '0;
    b_flush = 0;
  endtask

  initial begin
    idle();
    #12 reset = 1'b1;
    step();
    chk_b = 1;

    // Reset state
    chk("rst_busy", a_busy, 32'h0);
    chk("rst_ready", {29'h0, a_rd_ready}, 32'h7);
    chk("rst_rd0", a_rd_data[31:0], 32'h0);

    // Two ports, same index: port 1 wins
    a_wr_en = 2'b11;
    a_wr_idx = {5'd3, 5'd3};
    a_wr_data = {32'h5555, 32'hAAAA};
    step();
    idle();
    a_rd_idx = {5'd0, 5'd0, 5'd3};
    #1;
    chk("wr_conflict", a_rd_data[31:0], 32'h5555);
    chk("wr_conflict_mon", a_regs[3*32 +: 32], 32'h5555);

    // x0 write discarded, x0 read 0 even when bypass would match
    a_wr_en = 2'b01;
    a_wr_idx = {5'd0, 5'd0};
    a_wr_data = {32'h0, 32'hFFFF};
    a_rd_idx = {5'd0, 5'd0, 5'd0};
    #1;
    chk("x0_byp", a_rd_data[63:32], 32'h0);
    step();
    idle();
    chk("x0_mon", a_regs[31:0], 32'h0);
    chk("x0_rd", a_rd_data[31:0], 32'h0);

    // Bypass on build A
    a_wr_en = 2'b01;
    a_wr_idx = {5'd0, 5'd7};
    a_wr_data = {32'h0, 32'hDEAD};
    a_rd_idx = {5'd0, 5'd0, 5'd7};
    #1;
    chk("byp_data", a_rd_data[31:0], 32'hDEAD);
    chk("byp_rdy", {31'h0, a_rd_ready[0]}, 32'h1);
    step();
    idle();

    // No bypass on build B: old value, then new value
    b_wr_en = 3'b100;
    b_wr_idx = {4'd7, 4'd0, 4'd0};
    b_wr_data = {32'h1111, 64'h0};
    step();
    idle();
    b_wr_en = 3'b001;
    b_wr_idx = {4'd0, 4'd0, 4'd7};
    b_wr_data = {64'h0, 32'hDEAD};
    b_rd_idx = {12'h0, 4'd7};
    #1;
    chk("nobyp_old", b_rd_data[31:0], 32'h1111);
    step();
    b_wr_en = '0;
    #1;
    chk("nobyp_new", b_rd_data[31:0], 32'hDEAD);
    idle();

    // Alloc, then write-back with bypass
    a_alloc_en = 1;
    a_alloc_idx = 5'd9;
    step();
    idle();
    a_rd_idx = {5'd9, 5'd0, 5'd0};
    #1;
    chk("alloc_busy", a_busy, 32'h0000_0200);
    chk("alloc_notrdy", {31'h0, a_rd_ready[2]}, 32'h0);
    a_wr_en = 2'b10;
    a_wr_idx = {5'd9, 5'd0};
    a_wr_data = {32'h42, 32'h0};
    #1;
    chk("wb_byp_data", a_rd_data[95:64], 32'h42);
    chk("wb_byp_rdy", {31'h0, a_rd_ready[2]}, 32'h1);
    step();
    a_wr_en = '0;
    #1;
    chk("wb_clear", a_busy, 32'h0);
    chk("wb_stored", a_rd_data[95:64], 32'h42);

    // Alloc and write-back together: alloc wins
    a_alloc_en = 1;
    a_alloc_idx = 5'd9;
    a_wr_en = 2'b01;
    a_wr_idx = {5'd0, 5'd9};
    a_wr_data = {32'h0, 32'h77};
    step();
    idle();
    chk("alloc_wins", a_busy, 32'h0000_0200);

    // Flush beats a same-cycle alloc
    a_alloc_en = 1;
    a_alloc_idx = 5'd9;
    a_flush = 1;
    step();
    idle();
    chk("flush_wins", a_busy, 32'h0);

    // Alloc x0 has no effect
    a_alloc_en = 1;
    a_alloc_idx = 5'd0;
    step();
    idle();
    chk("alloc_x0", a_busy, 32'h0);

    // Asynchronous reset mid-run
    a_wr_en = 2'b01;
    a_wr_idx = {5'd0, 5'd5};
    a_wr_data = {32'h0, 32'h1234};
    a_alloc_en = 1;
    a_alloc_idx = 5'd5;
    step();
    idle();
    a_rd_idx = {5'd0, 5'd0, 5'd5};
    #1;
    chk("pre_rst_x5", a_regs[5*32 +: 32], 32'h1234);
    chk("pre_rst_busy", a_busy, 32'h0000_0020);
    #1 reset = 1'b0;
    #1;
    chk("arst_x5", a_regs[5*32 +: 32], 32'h0);
    chk("arst_busy", a_busy, 32'h0);
    chk("arst_rdy", {29'h0, a_rd_ready}, 32'h7);
    #2 reset = 1'b1;
    step();

    // Random traffic on build B, checked every cycle against the model
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 3; k++) begin
        b_wr_en[k] = 1'($urandom_range(0, 1));
        b_wr_idx[k*4 +: 4] = 4'($urandom_range(0, 15));
        b_wr_data[k*32 +: 32] = $urandom;
      end
      for (int j = 0; j < 4; j++)
        b_rd_idx[j*4 +: 4] = 4'($urandom_range(0, 15));
      b_alloc_en = 1'($urandom_range(0, 1));
      b_alloc_idx = 4'($urandom_range(0, 15));
      b_flush = ($urandom_range(0, 31) == 0);
      step();
    end
    idle();
    step();
    chk_b = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
